bootrom_loader: RTL and testbench



---
 rtl/bootrom_loader.sv | 170 +++++++++++++++++
 tb/tb_bootrom_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bootrom_loader.sv
// rtl/bootrom_loader.sv - boot ROM to RAM copy sequencer and boot ROM port arbiter
//
// After reset the CPU is held while every ROM word 0..WORDS-1 is read and written
// to RAM at DEST_BASE+index through a req/ack port. Once the copy completes, the
// ROM read port is handed to the CPU as a combinational pass-through.
//
// Ports:
//   romclk, rst              clock (rising edge), asynchronous active-high reset
//   restart                  1-cycle pulse, re-runs the copy from DONE or FAULT
//   rom_cs/rom_we/rom_addr   boot ROM control (rom_we is tied low)
//   rom_dout                 boot ROM read data
//   ram_req/ram_we/ram_addr  RAM write request, enable (same as req), address
//   ram_wdata/ram_ack        RAM write data, RAM write accepted this cycle
//   cpu_rom_cs/cpu_rom_addr  CPU ROM select and address, honoured in DONE only
//   cpu_rom_rdata            ROM data to the CPU, wired straight from rom_dout
//   cpu_hold/done/err        CPU stall, copy finished, copy aborted on ack timeout

module bootrom_loader #(
   parameter int WORDS       = 32,
   parameter int RAM_AW      = 12,
   parameter int DEST_BASE   = 0,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic              romclk,
   input  logic              rst,
   input  logic              restart,
   output logic              rom_cs,
   output logic              rom_we,
   output logic [4:0]        rom_addr,
   input  logic [15:0]       rom_dout,
   output logic              ram_req,
   output logic              ram_we,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [15:0]       ram_wdata,
   input  logic              ram_ack,
   input  logic              cpu_rom_cs,
   input  logic [4:0]        cpu_rom_addr,
   output logic [15:0]       cpu_rom_rdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              err
);

   localparam logic [4:0]        LAST_IDX = 5'(WORDS - 1);
   localparam logic [7:0]        TMO_LAST = 8'(ACK_TIMEOUT - 1);
   localparam logic [RAM_AW-1:0] BASE     = RAM_AW'(DEST_BASE);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_CAPT,
      S_WRITE,
      S_DONE,
      S_FAULT
   } state_t;

   state_t      state, state_n;
   logic [4:0]  idx,   idx_n;
   logic [15:0] data,  data_n;
   logic [7:0]  tmo,   tmo_n;

   // Registered copies of the sequencer-driven outputs
   logic              rom_cs_q;
   logic [4:0]        rom_addr_q;
   logic              ram_req_q;
   logic [RAM_AW-1:0] ram_addr_q;
   logic [15:0]       ram_wdata_q;
   logic              cpu_hold_q;
   logic              done_q;
   logic              err_q;

   always_ff @(posedge romclk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         idx   <= '0;
         data  <= '0;
         tmo   <= '0;
      end else begin
         state <= state_n;
         idx   <= idx_n;
         data  <= data_n;
         tmo   <= tmo_n;
      end
   end

   always_comb begin
      state_n = state;
      idx_n   = idx;
      data_n  = data;
      tmo_n   = tmo;
      case (state)
         S_IDLE: begin
            state_n = S_READ;
         end
         S_READ: begin
            state_n = S_CAPT;
         end
         S_CAPT: begin
            data_n  = rom_dout;
            tmo_n   = '0;
            state_n = S_WRITE;
         end
         S_WRITE: begin
            if (ram_ack) begin
               if (idx == LAST_IDX) begin
                  state_n = S_DONE;
               end else begin
                  idx_n   = idx + 5'd1;
                  state_n = S_READ;
               end
            end else if (tmo == TMO_LAST) begin
               // idx is left untouched so the failing word stays visible
               state_n = S_FAULT;
            end else begin
               tmo_n = tmo + 8'd1;
            end
         end
         S_DONE, S_FAULT: begin
            if (restart) begin
               idx_n   = '0;
               state_n = S_IDLE;
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so they change on the same edge
   // as the state itself, while still coming straight out of flops.
   always_ff @(posedge romclk or posedge rst) begin
      if (rst) begin
         rom_cs_q    <= 1'b0;
         rom_addr_q  <= '0;
         ram_req_q   <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         cpu_hold_q  <= 1'b1;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         rom_cs_q   <= (state_n == S_READ) || (state_n == S_CAPT);
         rom_addr_q <= ((state_n == S_READ) || (state_n == S_CAPT)) ? idx_n : 5'd0;
         ram_req_q  <= (state_n == S_WRITE);
         if (state_n == S_WRITE) begin
            ram_addr_q  <= BASE + RAM_AW'(idx_n);
            ram_wdata_q <= data_n;
         end
         cpu_hold_q <= (state_n != S_DONE);
         done_q     <= (state_n == S_DONE);
         err_q      <= (state_n == S_FAULT);
      end
   end

   // In DONE the CPU owns the ROM port directly, with no added latency
   assign rom_cs        = (state == S_DONE) ? cpu_rom_cs   : rom_cs_q;
   assign rom_addr      = (state == S_DONE) ? cpu_rom_addr : rom_addr_q;
   assign rom_we        = 1'b0;
   assign cpu_rom_rdata = rom_dout;

   assign ram_req   = ram_req_q;
   assign ram_we    = ram_req_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign cpu_hold  = cpu_hold_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_bootrom_loader.sv
// tb/tb_bootrom_loader.sv - directed/randomized bench for bootrom_loader

module tb_bootrom_loader;

   localparam int WORDS       = 32;
   localparam int RAM_AW      = 12;
   localparam int DEST_BASE   = 0;
   localparam int ACK_TIMEOUT = 255;

   logic              romclk = 1'b0;
   logic              rst = 1'b1;
   logic              restart = 1'b0;
   logic              rom_cs;
   logic              rom_we;
   logic [4:0]        rom_addr;
   logic [15:0]       rom_dout;
   logic              ram_req;
   logic              ram_we;
   logic [RAM_AW-1:0] ram_addr;
   logic [15:0]       ram_wdata;
   logic              ram_ack = 1'b1;
   logic              cpu_rom_cs = 1'b0;
   logic [4:0]        cpu_rom_addr = 5'd0;
   logic [15:0]       cpu_rom_rdata;
   logic              cpu_hold;
   logic              done;
   logic              err;

   logic [15:0] rom [32];
   assign rom_dout = rom_cs ? rom[rom_addr] : 16'hDEAD;

   always #5 romclk = ~romclk;

   bootrom_loader #(
      .WORDS(WORDS), .RAM_AW(RAM_AW), .DEST_BASE(DEST_BASE), .ACK_TIMEOUT(ACK_TIMEOUT)
   ) dut (
      .romclk(romclk), .rst(rst), .restart(restart),
      .rom_cs(rom_cs), .rom_we(rom_we), .rom_addr(rom_addr), .rom_dout(rom_dout),
      .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_ack(ram_ack),
      .cpu_rom_cs(cpu_rom_cs), .cpu_rom_addr(cpu_rom_addr), .cpu_rom_rdata(cpu_rom_rdata),
      .cpu_hold(cpu_hold), .done(done), .err(err)
   );

   int checks = 0;
   int errors = 0;
   int edge_cnt = 0;
   int inv_bad = 0;
   int ack_mode = 0;   // 0: always ack, 1: delay ack_delay cycles on ack_word, 2: never ack from ack_word on
   int ack_word = 0;
   int ack_delay = 0;
   int wait_cnt = 0;
   logic [RAM_AW+15:0] wr_q [$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Decide ram_ack for the coming edge and log the write that edge will complete
   task automatic set_ack();
      if (ack_mode == 0) begin
         ram_ack = 1'b1;
      end else if (ack_mode == 1) begin
         if (ram_req && ram_addr == RAM_AW'(DEST_BASE + ack_word)) begin
            wait_cnt++;
            ram_ack = (wait_cnt > ack_delay);
         end else begin
            ram_ack = 1'b1;
         end
      end else begin
         ram_ack = !(ram_req && ram_addr >= RAM_AW'(DEST_BASE + ack_word));
      end
      if (ram_req && ram_ack) wr_q.push_back({ram_addr, ram_wdata});
   endtask

   task automatic tick();
      @(posedge romclk);
      edge_cnt++;
      @(negedge romclk);
      if (rom_we !== 1'b0 || ram_we !== ram_req || cpu_hold !== ~done || (done && err))
         inv_bad++;
      set_ack();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      restart = 1'b0;
      repeat (3) @(negedge romclk);
      wr_q.delete();
      wait_cnt = 0;
      inv_bad = 0;
      rst = 1'b0;
      edge_cnt = 0;
      set_ack();
   endtask

   task automatic run_until(input int max_edges, output int hit_edge);
      hit_edge = 0;
      while (edge_cnt < max_edges && hit_edge == 0) begin
         tick();
         if (done || err) hit_edge = edge_cnt;
      end
   endtask

   task automatic check_copy(input string tag);
      chk({tag, "_count"}, 64'(wr_q.size()), 64'(WORDS));
      for (int i = 0; i < WORDS; i++) begin
         if (i < wr_q.size())
            chk($sformatf("%s_w%0d", tag, i), 64'(wr_q[i]),
                64'({RAM_AW'(DEST_BASE + i), rom[i]}));
      end
      chk({tag, "_invariants"}, 64'(inv_bad), 64'd0);
   endtask

   initial begin
      int e;
      int a;
      int base_done;

      base_done = 1 + 3 * WORDS;
      for (int i = 0; i < 32; i++) rom[i] = 16'($urandom);
      rom[0]  = 16'hF200;
      rom[27] = 16'h501E;
      rom[31] = 16'hC01E;

      // CPU side requests the ROM throughout; it must be ignored outside DONE
      cpu_rom_cs   = 1'b1;
      cpu_rom_addr = 5'($urandom_range(0, 31));

      // Reset state
      repeat (2) @(negedge romclk);
      chk("reset_outputs",
          64'({rom_cs, rom_addr, ram_req, ram_addr, ram_wdata, cpu_hold, done, err, rom_we}),
          64'({1'b0, 5'd0, 1'b0, {RAM_AW{1'b0}}, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0}));

      // Baseline copy with ack tied high
      ack_mode = 0;
      do_reset();
      run_until(400, e);
      chk("base_done_edge", 64'(e), 64'(base_done));
      chk("base_done", 64'(done), 64'd1);
      chk("base_hold", 64'(cpu_hold), 64'd0);
      chk("base_err", 64'(err), 64'd0);
      chk("base_req_idle", 64'(ram_req), 64'd0);
      check_copy("base");

      // CPU pass-through in DONE
      cpu_rom_cs   = 1'b1;
      cpu_rom_addr = 5'h1B;
      #1;
      chk("pt_addr", 64'(rom_addr), 64'h1B);
      chk("pt_cs", 64'(rom_cs), 64'd1);
      chk("pt_rdata", 64'(cpu_rom_rdata), 64'h501E);
      chk("pt_we", 64'(rom_we), 64'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         a = $urandom_range(0, 31);
         cpu_rom_addr = 5'(a);
         #1;
         chk($sformatf("pt_rand_rdata%0d", k), 64'(cpu_rom_rdata), 64'(rom[a]));
         chk($sformatf("pt_rand_addr%0d", k), 64'(rom_addr), 64'(a));
      end
      tick();
      cpu_rom_cs = 1'b0;
      #1;
      chk("pt_cs_off", 64'(rom_cs), 64'd0);
      cpu_rom_cs = 1'b1;

      // Ack delayed 4 cycles on word 5
      ack_mode = 1; ack_word = 5; ack_delay = 4;
      do_reset();
      run_until(400, e);
      chk("delay_done_edge", 64'(e), 64'(base_done + 4));
      chk("delay_req_cycles", 64'(wait_cnt), 64'd5);
      check_copy("delay");

      // Randomly placed, randomly sized ack delay
      ack_mode = 1;
      ack_word = $urandom_range(0, WORDS - 1);
      ack_delay = $urandom_range(1, 12);
      do_reset();
      run_until(400, e);
      chk("rdelay_done_edge", 64'(e), 64'(base_done + ack_delay));
      chk("rdelay_req_cycles", 64'(wait_cnt), 64'(ack_delay + 1));
      check_copy("rdelay");

      // Ack withheld from word 3: timeout, fault, then restart
      ack_mode = 2; ack_word = 3;
      do_reset();
      run_until(800, e);
      chk("tmo_err_edge", 64'(e), 64'(3 * ack_word + 3 + ACK_TIMEOUT));
      chk("tmo_err", 64'(err), 64'd1);
      chk("tmo_addr", 64'(ram_addr), 64'(DEST_BASE + 3));
      chk("tmo_idx", 64'(dut.idx), 64'd3);
      chk("tmo_hold", 64'(cpu_hold), 64'd1);
      chk("tmo_done", 64'(done), 64'd0);
      chk("tmo_rom_cs", 64'(rom_cs), 64'd0);
      chk("tmo_req", 64'(ram_req), 64'd0);
      chk("tmo_writes", 64'(wr_q.size()), 64'd3);
      repeat (5) tick();
      chk("tmo_sticky", 64'({err, dut.idx}), 64'({1'b1, 5'd3}));
      ack_mode = 0;
      restart = 1'b1;
      tick();
      restart = 1'b0;
      chk("rs_err_clr", 64'(err), 64'd0);
      chk("rs_hold", 64'(cpu_hold), 64'd1);
      edge_cnt = 0;
      wr_q.delete();
      inv_bad = 0;
      run_until(400, e);
      chk("rs_done_edge", 64'(e), 64'(base_done));
      chk("rs_flags", 64'({done, err}), 64'({1'b1, 1'b0}));
      check_copy("rs");

      // Reset during WRITE of word 10
      ack_mode = 1; ack_word = 10; ack_delay = 1000;
      do_reset();
      while (!(ram_req && ram_addr == RAM_AW'(DEST_BASE + 10)) && edge_cnt < 200) tick();
      chk("mid_in_write", 64'(ram_req && ram_addr == RAM_AW'(DEST_BASE + 10)), 64'd1);
      #1 rst = 1'b1;
      #1;
      chk("mid_req_drop", 64'(ram_req), 64'd0);
      chk("mid_hold", 64'(cpu_hold), 64'd1);
      ack_mode = 0;
      do_reset();
      run_until(400, e);
      chk("mid_done_edge", 64'(e), 64'(base_done));
      check_copy("mid");

      // restart during READ is ignored
      ack_mode = 0;
      do_reset();
      tick();
      chk("rd_in_read", 64'(rom_cs), 64'd1);
      restart = 1'b1;
      tick();
      restart = 1'b0;
      run_until(400, e);
      chk("rd_done_edge", 64'(e), 64'(base_done));
      check_copy("rd");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
